// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: definitions shared across the system controller.
// Holds the response-generator FSM state type, the response kind type and the
// frame header codes that the command analyzer also uses as command codes.
package sys_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY0,
    PAY1
  } rsp_state_t;

  typedef enum logic {
    RD,
    ALU
  } rsp_kind_t;

  localparam logic [7:0] RD_HDR  = 8'hBB;
  localparam logic [7:0] ALU_HDR = 8'hCC;

endpackage

// File: rtl/rsp_frm_gen.sv
// rsp_frm_gen: response frame generator on the transmit side.
// Captures a register-read result or an ALU result and serialises it to the UART
// transmitter as a header byte followed by payload bytes, with valid/ready flow control.
//   RD frame : 0xBB, rd_data
//   ALU frame: 0xCC, alu_out[7:0], alu_out[15:8]
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   rd_data_valid, rd_data   register-read request pulse and data
//   alu_out_valid, alu_out   ALU result request pulse and data
//   tx_ready                 UART transmitter accepts a byte this cycle
//   tx_p_data, tx_data_valid byte to transmit and its valid flag
//   rsp_busy                 frame loaded or in progress; requests are dropped
//   frame_done               one-cycle pulse after the last byte is accepted
//   drop_err                 one-cycle pulse after a request is discarded
// All outputs are registered; tx_ready only affects state on the next edge.
module rsp_frm_gen
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ALU_OUT_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     rd_data_valid,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  input  logic                     alu_out_valid,
  input  logic [ALU_OUT_WIDTH-1:0] alu_out,
  input  logic                     tx_ready,
  output logic [DATA_WIDTH-1:0]    tx_p_data,
  output logic                     tx_data_valid,
  output logic                     rsp_busy,
  output logic                     frame_done,
  output logic                     drop_err
);

  rsp_state_t               r_state, w_state_d;
  rsp_kind_t                r_kind, w_kind_d;
  logic [ALU_OUT_WIDTH-1:0] r_payload, w_payload_d;
  logic [DATA_WIDTH-1:0]    r_tx_p_data;
  logic                     r_tx_data_valid;
  logic                     r_rsp_busy;
  logic                     r_frame_done;
  logic                     r_drop_err;
  logic                     w_xfer;
  logic                     w_drop;
  logic                     w_present;

  assign w_xfer = r_tx_data_valid & tx_ready;

  // In IDLE only the losing ALU request of a simultaneous pair is dropped;
  // anywhere else every arriving request is dropped.
  assign w_drop = (r_state == IDLE) ? (rd_data_valid & alu_out_valid)
                                    : (rd_data_valid | alu_out_valid);

  always_comb begin
    w_state_d   = r_state;
    w_kind_d    = r_kind;
    w_payload_d = r_payload;
    unique case (r_state)
      IDLE: begin
        if (rd_data_valid) begin
          w_state_d   = HDR;
          w_kind_d    = RD;
          w_payload_d = ALU_OUT_WIDTH'(rd_data);
        end else if (alu_out_valid) begin
          w_state_d   = HDR;
          w_kind_d    = ALU;
          w_payload_d = alu_out;
        end
      end
      HDR: begin
        if (w_xfer) w_state_d = PAY0;
      end
      PAY0: begin
        if (w_xfer) w_state_d = (r_kind == RD) ? IDLE : PAY1;
      end
      PAY1: begin
        if (w_xfer) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  // The edge that enters HDR from IDLE only captures the request; the header is
  // loaded into the output register on the following edge, so a byte is presented
  // only when both the current and next state are busy.
  assign w_present = (r_state != IDLE) && (w_state_d != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state         <= IDLE;
      r_kind          <= RD;
      r_payload       <= '0;
      r_tx_p_data     <= '0;
      r_tx_data_valid <= 1'b0;
      r_rsp_busy      <= 1'b0;
      r_frame_done    <= 1'b0;
      r_drop_err      <= 1'b0;
    end else begin
      r_state         <= w_state_d;
      r_kind          <= w_kind_d;
      r_payload       <= w_payload_d;
      r_tx_data_valid <= w_present;
      r_rsp_busy      <= w_present;
      r_frame_done    <= (r_state != IDLE) && (w_state_d == IDLE);
      r_drop_err      <= w_drop;
      if (w_present) begin
        unique case (w_state_d)
          HDR:     r_tx_p_data <= (r_kind == RD) ? DATA_WIDTH'(RD_HDR) : DATA_WIDTH'(ALU_HDR);
          PAY0:    r_tx_p_data <= r_payload[DATA_WIDTH-1:0];
          PAY1:    r_tx_p_data <= r_payload[ALU_OUT_WIDTH-1:DATA_WIDTH];
          default: r_tx_p_data <= '0;
        endcase
      end else begin
        r_tx_p_data <= '0;
      end
    end
  end

  assign tx_p_data     = r_tx_p_data;
  assign tx_data_valid = r_tx_data_valid;
  assign rsp_busy      = r_rsp_busy;
  assign frame_done    = r_frame_done;
  assign drop_err      = r_drop_err;

endmodule
